dmem_ctrl: RTL and testbench

Single-port data-memory controller that sits directly downstream of the core's load/store unit and serves its read and write requests from an on-chip word array. It accepts one request at a time, inserts a configurable number of wait states, and returns read data with a one-cycle valid pulse. It also drives a busy flag that the LSU uses to hold off the next access.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_sram.sv | 38 +++
 rtl/dmem_ctrl.sv | 148 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory controller.
//   - FSM state encoding
//   - default geometry / timing constants
//   - word-index width helper
package dmem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int unsigned DEF_DEPTH       = 1024;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
  localparam int unsigned DEF_WAIT_CYCLES = 1;

  // Number of bits needed to index DEPTH words (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// dmem_sram: single-port DEPTH x 32 word array, synchronous write and
// synchronous read. Contents are not reset.
// Ports:
//   clock  in   clock
//   we     in   write enable (writes wdata to idx)
//   re     in   read enable (rdata <= array[idx] next edge)
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  registered read data, holds between reads
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned IW    = idx_width(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[idx];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data-memory controller for the load/store unit.
// Accepts one read or write at a time, inserts WAIT_CYCLES wait states and
// answers in a single RESP cycle.
// Optional feature macro: DMEM_ADDR_CHECK_EN adds address checking and the
// err_o port; without it addresses wrap silently.
// Ports:
//   clock      in   clock, rising edge
//   reset      in   synchronous active-low reset
//   addr_i     in   byte address
//   w_req_i    in   write request (sampled in IDLE, wins over read)
//   w_data_i   in   write data
//   r_req_i    in   read request (sampled in IDLE)
//   r_data_o   out  read data, holds last read value
//   r_valid_o  out  one-cycle read-valid pulse in RESP
//   busy_o     out  access in flight
//   err_o      out  error pulse in RESP (DMEM_ADDR_CHECK_EN only)
//
// state | meaning
// IDLE  | waiting for a request
// WAIT  | counting wait states down to zero
// RESP  | write committed / read data presented
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr_i,
  input  logic        w_req_i,
  input  logic [31:0] w_data_i,
  input  logic        r_req_i,
  output logic [31:0] r_data_o,
  output logic        r_valid_o,
  output logic        busy_o
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic        err_o
`endif
);

  localparam int unsigned IW       = idx_width(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_op_wr;
  logic          r_flag;
  logic [31:0]   r_hold;

  logic [32:0]   w_diff;
  logic [31:0]   w_off;
  logic [IW-1:0] w_in_idx;
  logic [IW-1:0] w_sram_idx;
  logic          w_req;
  logic          w_flag_in;
  logic          w_rd_issue;
  logic          w_we;
  logic          w_rd_resp;
  logic [31:0]   w_sram_rdata;
  logic          w_unused;

  // Extra top bit carries the borrow, i.e. addr_i below BASE_ADDR.
  assign w_diff   = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign w_off    = w_diff[31:0];
  assign w_in_idx = w_off[IW+1:2];
  assign w_req    = w_req_i | r_req_i;
  assign w_unused = ^{w_diff[32], w_off[31:IW+2], w_off[1:0]};

`ifdef DMEM_ADDR_CHECK_EN
  assign w_flag_in = (addr_i[1:0] != 2'b00) || w_diff[32] || (w_off >= DEPTH * 4);
`else
  assign w_flag_in = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_op_wr <= 1'b0;
      r_flag  <= 1'b0;
      r_hold  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_idx   <= w_in_idx;
            r_wdata <= w_data_i;
            r_op_wr <= w_req_i;
            r_flag  <= w_flag_in;
            r_cnt   <= CNT_INIT;
            r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          if (!r_op_wr) begin
            r_hold <= r_data_o;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The array read is launched one cycle ahead of RESP so its registered
  // output lines up with RESP. With zero wait states that cycle is IDLE,
  // so the index comes straight from addr_i.
  assign w_rd_issue = ((r_state == ST_WAIT) && (r_cnt == 4'd0) && !r_op_wr) ||
                      ((r_state == ST_IDLE) && (WAIT_CYCLES == 0) && r_req_i && !w_req_i);
  assign w_sram_idx = (r_state == ST_IDLE) ? w_in_idx : r_idx;
  assign w_we       = (r_state == ST_RESP) && r_op_wr && !r_flag;

  dmem_sram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_sram (
    .clock (clock),
    .we    (w_we),
    .re    (w_rd_issue),
    .idx   (w_sram_idx),
    .wdata (r_wdata),
    .rdata (w_sram_rdata)
  );

  assign w_rd_resp = (r_state == ST_RESP) && !r_op_wr;
  assign r_valid_o = w_rd_resp;
  assign busy_o    = (r_state != ST_IDLE);
  assign r_data_o  = w_rd_resp ? (r_flag ? 32'h0 : w_sram_rdata) : r_hold;

`ifdef DMEM_ADDR_CHECK_EN
  assign err_o = (r_state == ST_RESP) && r_flag;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl. Three instances with
// WAIT_CYCLES = 1, 0 and 3 share one clock; each has its own inputs.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [3];
  logic [31:0] addr   [3];
  logic [31:0] wdat   [3];
  logic        wreq   [3];
  logic        rreq   [3];
  logic [31:0] rdata  [3];
  logic        rvalid [3];
  logic        busy   [3];
`ifdef DMEM_ADDR_CHECK_EN
  logic        err    [3];
`endif

  int waits [3] = '{1, 0, 3};
  int total = 0;
  int bad   = 0;
  int pulses;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_ctrl #(
      .DEPTH       (1024),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clock     (clk),
      .reset     (rst_n[g]),
      .addr_i    (addr[g]),
      .w_req_i   (wreq[g]),
      .w_data_i  (wdat[g]),
      .r_req_i   (rreq[g]),
      .r_data_o  (rdata[g]),
      .r_valid_o (rvalid[g]),
      .busy_o    (busy[g])
`ifdef DMEM_ADDR_CHECK_EN
      ,
      .err_o     (err[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on instance k, starting at a falling edge with the DUT idle.
  // Walks busy/valid/data/err through every cycle of the access and checks
  // the DUT is idle again afterwards.
  task automatic access(input int k, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic expv, input logic [31:0] expd, input logic expe);
    wreq[k] = wr;
    rreq[k] = rd;
    addr[k] = a;
    wdat[k] = d;
    @(negedge clk);
    wreq[k] = 1'b0;
    rreq[k] = 1'b0;
    for (int c = 0; c <= waits[k]; c++) begin
      chk($sformatf("busy%0d_c%0d", k, c), busy[k], 1);
      chk($sformatf("valid%0d_c%0d", k, c), rvalid[k], (c == waits[k]) && expv);
      if ((c == waits[k]) && expv) begin
        chk($sformatf("rdata%0d_a%h", k, a), rdata[k], expd);
      end
`ifdef DMEM_ADDR_CHECK_EN
      chk($sformatf("err%0d_c%0d", k, c), err[k], (c == waits[k]) && expe);
`endif
      @(negedge clk);
    end
    chk($sformatf("idle_busy%0d", k), busy[k], 0);
    chk($sformatf("idle_valid%0d", k), rvalid[k], 0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      addr[k]  = 32'h0;
      wdat[k]  = 32'h0;
      wreq[k]  = 1'b0;
      rreq[k]  = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
      chk($sformatf("rst_valid%0d", k), rvalid[k], 0);
      chk($sformatf("rst_busy%0d", k), busy[k], 0);
`ifdef DMEM_ADDR_CHECK_EN
      chk($sformatf("rst_err%0d", k), err[k], 0);
`endif
      rst_n[k] = 1'b1;
    end
    @(negedge clk);

    // Write then read, one wait state: busy for 2 cycles, valid 2 cycles later.
    access(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 0, 32'h0, 0);
    access(0, 0, 1, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 0);
    chk("hold_rdata", rdata[0], 32'hDEAD_BEEF);

    // Simultaneous requests with zero wait states: write wins, no valid.
    access(1, 1, 1, 32'h4, 32'h1234_5678, 0, 32'h0, 0);
    access(1, 0, 1, 32'h4, 32'h0, 1, 32'h1234_5678, 0);
    access(1, 1, 0, 32'h8, 32'h5555_0008, 0, 32'h0, 0);
    access(1, 0, 1, 32'h8, 32'h0, 1, 32'h5555_0008, 0);

    // Read held high continuously: accepted at 0 and 3, valid at 2 and 5.
    access(0, 1, 0, 32'h20, 32'hCAFE_0001, 0, 32'h0, 0);
    rreq[0] = 1'b1;
    addr[0] = 32'h20;
    pulses  = 0;
    for (int c = 0; c < 7; c++) begin
      chk($sformatf("bb_busy_c%0d", c), busy[0], (c == 1) || (c == 2) || (c == 4) || (c == 5));
      chk($sformatf("bb_valid_c%0d", c), rvalid[0], (c == 2) || (c == 5));
      if (rvalid[0]) begin
        pulses++;
        chk("bb_rdata", rdata[0], 32'hCAFE_0001);
      end
      if (c == 6) rreq[0] = 1'b0;
      @(negedge clk);
    end
    chk("bb_pulses", pulses, 2);
    chk("bb_idle", busy[0], 0);

    access(0, 1, 0, 32'h0, 32'h1111_0000, 0, 32'h0, 0);
`ifdef DMEM_ADDR_CHECK_EN
    // Misaligned read and out-of-range write are flagged; word 0 untouched.
    access(0, 0, 1, 32'h3, 32'h0, 1, 32'h0, 1);
    access(0, 1, 0, 32'h1000, 32'h9999_9999, 0, 32'h0, 1);
    access(0, 0, 1, 32'h0, 32'h0, 1, 32'h1111_0000, 0);
`else
    // Address wraps at DEPTH words; low address bits are ignored.
    access(0, 1, 0, 32'h1000, 32'hA5A5_A5A5, 0, 32'h0, 0);
    access(0, 0, 1, 32'h0, 32'h0, 1, 32'hA5A5_A5A5, 0);
    access(0, 0, 1, 32'h13, 32'h0, 1, 32'hDEAD_BEEF, 0);
`endif

    // Reset during WAIT with three wait states: write discarded.
    access(2, 1, 0, 32'h8, 32'h0BAD_F00D, 0, 32'h0, 0);
    access(2, 0, 1, 32'h8, 32'h0, 1, 32'h0BAD_F00D, 0);
    wreq[2] = 1'b1;
    addr[2] = 32'h8;
    wdat[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    wreq[2] = 1'b0;
    chk("mid_busy", busy[2], 1);
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy[2], 0);
    chk("mrst_valid", rvalid[2], 0);
    chk("mrst_rdata", rdata[2], 32'h0);
`ifdef DMEM_ADDR_CHECK_EN
    chk("mrst_err", err[2], 0);
`endif
    rst_n[2] = 1'b1;
    access(2, 0, 1, 32'h8, 32'h0, 1, 32'h0BAD_F00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
